// File: rtl/relu_ctrl_pkg.sv
// Shared FSM encoding and default geometry for the ReLU stream controller.
package relu_ctrl_pkg;

  localparam int BITWIDTH_DEF = 8;
  localparam int LANES_DEF    = 4;
  localparam int LEN_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/relu_lane_array.sv
// Combinational LANES-wide clamp; bypass routes each raw element around its ReLU.
module relu_lane_array
  import relu_ctrl_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF,
  parameter int LANES    = LANES_DEF
) (
  input  logic                      bypass,
  input  logic [LANES*BITWIDTH-1:0] din,
  output logic [LANES*BITWIDTH-1:0] dout
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [BITWIDTH-1:0] clamped;

    simple_relu #(.W(BITWIDTH)) u_relu (
      .x (din[i*BITWIDTH +: BITWIDTH]),
      .y (clamped)
    );

    assign dout[i*BITWIDTH +: BITWIDTH] = bypass ? din[i*BITWIDTH +: BITWIDTH] : clamped;
  end

endmodule

// File: rtl/simple_relu.sv
// Single-element signed ReLU: negative inputs become zero, others pass unchanged.
module simple_relu #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = x[W-1] ? '0 : x;

endmodule

// File: rtl/relu_stream_ctrl.sv
// Runs one ReLU/bypass job of cfg_len beats; one-cycle latency through a registered output stage.
// Backpressure: s_ready drops while the output register is full and m_ready is low; full rate otherwise.
// Optional RELU_ZCNT_EN adds zero_cnt, the number of elements the clamp forced to zero in the job.
module relu_stream_ctrl
  import relu_ctrl_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF,
  parameter int LANES    = LANES_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_start,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic                      cfg_bypass,
  output logic                      busy,
  output logic                      done,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*BITWIDTH-1:0] s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LANES*BITWIDTH-1:0] m_data,
  output logic                      m_last
`ifdef RELU_ZCNT_EN
  ,
  output logic [LEN_W+$clog2(LANES):0] zero_cnt
`endif
);

  localparam int DW = LANES * BITWIDTH;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] beat_cnt;
  logic             bypass_q;
  logic             start_acc;
  logic             load;
  logic             out_pop;
  logic             last_beat;
  logic [DW-1:0]    lane_out;

  assign start_acc = (state == IDLE) && cfg_start;
  assign s_ready   = (state == RUN) && (!m_valid || m_ready);
  assign load      = s_valid && s_ready;
  assign out_pop   = m_valid && m_ready;
  assign last_beat = (beat_cnt == last_idx);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = (cfg_len != '0) ? RUN : FIN;
      RUN:     if (load && last_beat) state_nxt = DRAIN;
      DRAIN:   if (out_pop && m_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Store len-1 so the final-beat compare is a plain equality against the beat index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_idx <= '0;
      bypass_q <= 1'b0;
      beat_cnt <= '0;
    end else if (start_acc) begin
      last_idx <= cfg_len - LEN_W'(1);
      bypass_q <= cfg_bypass;
      beat_cnt <= '0;
    end else if (load) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

  relu_lane_array #(
    .BITWIDTH (BITWIDTH),
    .LANES    (LANES)
  ) u_lanes (
    .bypass (bypass_q),
    .din    (s_data),
    .dout   (lane_out)
  );

  // A load in the same cycle as a pop refills the register, giving back-to-back beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_last  <= last_beat;
      m_data  <= lane_out;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

`ifdef RELU_ZCNT_EN
  localparam int NW = $clog2(LANES) + 1;
  localparam int ZW = LEN_W + NW;

  logic [NW-1:0] neg_lanes;

  always_comb begin
    neg_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!bypass_q && s_data[i*BITWIDTH + BITWIDTH - 1]) neg_lanes = neg_lanes + NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         zero_cnt <= '0;
    else if (start_acc) zero_cnt <= '0;
    else if (load)      zero_cnt <= zero_cnt + ZW'(neg_lanes);
  end
`endif

endmodule
